// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Control FSM for the iterative multiply/divide datapath.
//                A single-cycle start pulse produces a one-cycle operand
//                load strobe, then a fixed run of step strobes carrying a
//                0-based step index, and ends with a one-cycle result-ready
//                pulse that carries the exception flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MULT_STEPS   step cycles for a multiply (radix-4 Booth, 32-bit)
//    DIV_STEPS    step cycles for a divide
//    CNT_W        width of step_idx; 2**CNT_W must exceed both step counts
//  Ports
//    clk          system clock, rising-edge active
//    rst          synchronous, active-high reset
//    ctrl_mult    start multiply (single-cycle pulse)
//    ctrl_div     start divide (single-cycle pulse)
//    dp_exception datapath exception: divisor==0 (div) / overflow (mult)
//    dp_load      load operands into the datapath registers
//    dp_step      advance the datapath by one iteration
//    dp_op_div    latched operation, 1=div 0=mult
//    step_idx     current iteration index, 0-based
//    busy         high while loading or running
//    result_rdy   one-cycle pulse, result valid in the datapath
//    exception    exception flag, meaningful only with result_rdy
// ============================================================================
module muldiv_sequencer #(
    parameter int MULT_STEPS = 16,
    parameter int DIV_STEPS  = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             dp_exception,
    output logic             dp_load,
    output logic             dp_step,
    output logic             dp_op_div,
    output logic [CNT_W-1:0] step_idx,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] c_DIV_LAST  = CNT_W'(DIV_STEPS - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_op_div;
    logic             r_exc;
    logic [CNT_W-1:0] r_step_idx;

    logic             w_start;
    logic             w_start_div;
    logic [CNT_W-1:0] w_last_idx;
    logic             w_last_step;
    logic             w_div_by_zero;
    logic             w_mult_ovf;

    // A start pulse wins over everything but reset; when both requests
    // arrive together the multiply is taken.
    assign w_start     = ctrl_mult | ctrl_div;
    assign w_start_div = ctrl_div & ~ctrl_mult;

    assign w_last_idx  = r_op_div ? c_DIV_LAST : c_MULT_LAST;
    assign w_last_step = (r_step_idx == w_last_idx);

    // Divide-by-zero is flagged while operands are loaded so the run is
    // skipped; multiply overflow is only known after the final step.
    assign w_div_by_zero = (r_state == ST_LOAD) && r_op_div && dp_exception;
    assign w_mult_ovf    = (r_state == ST_RUN) && w_last_step && !r_op_div
                           && dp_exception;

    // ------------------------------------------------------------------
    // State, op latch, exception latch and step counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op_div   <= 1'b0;
            r_exc      <= 1'b0;
            r_step_idx <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Entry to LOAD only ever happens through a start, so this is
            // also where the exception latch is cleared.
            if (w_start) begin
                r_op_div <= w_start_div;
                r_exc    <= 1'b0;
            end else if (w_div_by_zero || w_mult_ovf) begin
                r_exc    <= 1'b1;
            end

            // Count only while staying in RUN; any exit (done, restart)
            // returns the index to zero so it can never wrap.
            if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
                r_step_idx <= r_step_idx + c_ONE;
            end else begin
                r_step_idx <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        dp_load     = 1'b0;
        dp_step     = 1'b0;
        busy        = 1'b0;
        result_rdy  = 1'b0;
        exception   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                dp_load     = 1'b1;
                busy        = 1'b1;
                w_state_nxt = w_div_by_zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                dp_step     = 1'b1;
                busy        = 1'b1;
                w_state_nxt = w_last_step ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                result_rdy  = 1'b1;
                exception   = r_exc;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Restart from any state; an aborted op never reaches DONE, while a
        // start seen in DONE still lets this cycle's pulse out.
        if (w_start) begin
            w_state_nxt = ST_LOAD;
        end
    end

    assign dp_op_div = r_op_div;
    assign step_idx  = r_step_idx;

endmodule
`default_nettype wire
